psola_stream_scheduler: RTL and testbench

- Sequences the window-based pitch-shift output path: captures incoming samples into a two-bank window store and launches the PSOLA engine once per completed window with the latest tau.
- Tracks output ring-buffer occupancy and paces playback reads at a fixed sample rate.
- Sits between the audio sample source, the YIN tau producer, the PSOLA engine and the output ring buffer, replacing ad-hoc start/read glue.

---
 rtl/psola_stream_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_psola_stream_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psola_stream_scheduler.sv
// Sequencer for the PSOLA pitch-shift output path: window capture into a two-bank
// store, engine launch per completed window, ring occupancy and playback pacing.
module psola_stream_scheduler #(
    parameter int unsigned WINDOW_SIZE       = 2048,
    parameter int unsigned MAX_EXTENDED      = 2200,
    parameter int unsigned RING_ENTRIES      = 4400,
    parameter int unsigned START_THRESHOLD   = 2200,
    parameter int unsigned CYCLES_PER_SAMPLE = 2304,
    parameter logic [10:0] DEFAULT_TAU       = 11'd100,
    localparam int unsigned ADDR_W = $clog2(WINDOW_SIZE),
    localparam int unsigned OCC_W  = $clog2(RING_ENTRIES + 1)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              sample_valid_in,
    input  logic [10:0]       taumin_in,
    input  logic              taumin_valid_in,
    input  logic              psola_write_in,
    input  logic              psola_done_in,
    output logic              sample_we_out,
    output logic [ADDR_W-1:0] sample_addr_out,
    output logic              sample_bank_out,
    output logic              psola_start_out,
    output logic              psola_bank_out,
    output logic [10:0]       psola_tau_out,
    output logic              read_trigger_out,
    output logic [OCC_W-1:0]  occupancy_out,
    output logic              underrun_out,
    output logic              overrun_out,
    output logic              dropped_window_out,
    output logic              playing_out
);

    localparam int unsigned PACE_W = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WINDOW_SIZE - 1);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(RING_ENTRIES);
    localparam logic [OCC_W-1:0]  OCC_NEED  = OCC_W'(MAX_EXTENDED);
    localparam logic [OCC_W-1:0]  OCC_START = OCC_W'(START_THRESHOLD);
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(CYCLES_PER_SAMPLE - 1);

    typedef enum logic { ENG_IDLE, ENG_RUN } eng_state_t;
    typedef enum logic { PB_PRIME, PB_PLAY } pb_state_t;

    eng_state_t        eng_state_q;
    pb_state_t         pb_state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_bank_q;
    logic              win_ready_q;
    logic              win_bank_q;
    logic [10:0]       tau_q;
    logic [PACE_W-1:0] pace_q;

    logic              sample_we_q, sample_bank_q, psola_start_q, psola_bank_q;
    logic [ADDR_W-1:0] sample_addr_q;
    logic [10:0]       psola_tau_q;
    logic              read_trigger_q, underrun_q, overrun_q, dropped_q, playing_q;
    logic [OCC_W-1:0]  occupancy_q, occupancy_d;

    logic              ring_overrun_d;
    logic              eng_free;
    logic              has_room;
    logic [10:0]       tau_now;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        occupancy_d    = occupancy_q;
        ring_overrun_d = 1'b0;
        // A done pulse in the decision cycle frees the engine for that same window.
        eng_free       = (eng_state_q == ENG_IDLE) || psola_done_in;
        has_room       = (OCC_FULL - occupancy_q) >= OCC_NEED;
        tau_now        = taumin_valid_in ? taumin_in : tau_q;
        if (psola_write_in && !read_trigger_q) begin
            if (occupancy_q == OCC_FULL) begin
                ring_overrun_d = 1'b1;
            end else begin
                occupancy_d = occupancy_q + OCC_W'(1);
            end
        end else if (!psola_write_in && read_trigger_q && (occupancy_q != '0)) begin
            occupancy_d = occupancy_q - OCC_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            eng_state_q    <= ENG_IDLE;
            pb_state_q     <= PB_PRIME;
            wr_addr_q      <= '0;
            wr_bank_q      <= 1'b0;
            win_ready_q    <= 1'b0;
            win_bank_q     <= 1'b0;
            tau_q          <= DEFAULT_TAU;
            pace_q         <= '0;
            sample_we_q    <= 1'b0;
            sample_addr_q  <= '0;
            sample_bank_q  <= 1'b0;
            psola_start_q  <= 1'b0;
            psola_bank_q   <= 1'b0;
            psola_tau_q    <= '0;
            read_trigger_q <= 1'b0;
            underrun_q     <= 1'b0;
            overrun_q      <= 1'b0;
            dropped_q      <= 1'b0;
            playing_q      <= 1'b0;
            occupancy_q    <= '0;
        end else begin
            sample_we_q <= sample_valid_in;
            win_ready_q <= 1'b0;
            if (sample_valid_in) begin
                sample_addr_q <= wr_addr_q;
                sample_bank_q <= wr_bank_q;
                wr_addr_q     <= wr_addr_q + ADDR_W'(1);
                if (wr_addr_q == ADDR_LAST) begin
                    wr_addr_q   <= '0;
                    wr_bank_q   <= ~wr_bank_q;
                    win_ready_q <= 1'b1;
                    win_bank_q  <= wr_bank_q;
                end
            end
            if (taumin_valid_in) begin
                tau_q <= taumin_in;
            end

            psola_start_q <= 1'b0;
            dropped_q     <= 1'b0;
            overrun_q     <= ring_overrun_d;
            if (win_ready_q) begin
                if (eng_free && has_room) begin
                    psola_start_q <= 1'b1;
                    psola_bank_q  <= win_bank_q;
                    psola_tau_q   <= tau_now;
                    eng_state_q   <= ENG_RUN;
                end else if (eng_free) begin
                    overrun_q   <= 1'b1;
                    eng_state_q <= ENG_IDLE;
                end else begin
                    dropped_q <= 1'b1;
                end
            end else if (psola_done_in) begin
                eng_state_q <= ENG_IDLE;
            end

            occupancy_q    <= occupancy_d;
            read_trigger_q <= 1'b0;
            underrun_q     <= 1'b0;
            case (pb_state_q)
                PB_PRIME: begin
                    pace_q <= '0;
                    if (occupancy_q >= OCC_START) begin
                        pb_state_q <= PB_PLAY;
                        playing_q  <= 1'b1;
                    end
                end
                PB_PLAY: begin
                    if (pace_q == PACE_LAST) begin
                        pace_q <= '0;
                        if (occupancy_q != '0) begin
                            read_trigger_q <= 1'b1;
                        end else begin
                            underrun_q <= 1'b1;
                            pb_state_q <= PB_PRIME;
                            playing_q  <= 1'b0;
                        end
                    end else begin
                        pace_q <= pace_q + PACE_W'(1);
                    end
                end
                default: pb_state_q <= PB_PRIME;
            endcase
        end
    end

    assign sample_we_out      = sample_we_q;
    assign sample_addr_out    = sample_addr_q;
    assign sample_bank_out    = sample_bank_q;
    assign psola_start_out    = psola_start_q;
    assign psola_bank_out     = psola_bank_q;
    assign psola_tau_out      = psola_tau_q;
    assign read_trigger_out   = read_trigger_q;
    assign occupancy_out      = occupancy_q;
    assign underrun_out       = underrun_q;
    assign overrun_out        = overrun_q;
    assign dropped_window_out = dropped_q;
    assign playing_out        = playing_q;

endmodule

// File: tb/tb_psola_stream_scheduler.sv
// Bench for psola_stream_scheduler with small parameters: scoreboarded window writes
// and engine starts, plus per-cycle tables for occupancy and playback pacing.
module tb_psola_stream_scheduler;

    localparam int WS   = 8;
    localparam int MAXE = 6;
    localparam int RING = 8;
    localparam int THR  = 4;
    localparam int CPS  = 4;
    localparam int AW   = $clog2(WS);
    localparam int OW   = $clog2(RING + 1);

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          sample_valid_in;
    logic [10:0]   taumin_in;
    logic          taumin_valid_in;
    logic          psola_write_in;
    logic          psola_done_in;
    logic          sample_we_out;
    logic [AW-1:0] sample_addr_out;
    logic          sample_bank_out;
    logic          psola_start_out;
    logic          psola_bank_out;
    logic [10:0]   psola_tau_out;
    logic          read_trigger_out;
    logic [OW-1:0] occupancy_out;
    logic          underrun_out;
    logic          overrun_out;
    logic          dropped_window_out;
    logic          playing_out;

    always #5 clk_in = ~clk_in;

    psola_stream_scheduler #(
        .WINDOW_SIZE(WS), .MAX_EXTENDED(MAXE), .RING_ENTRIES(RING),
        .START_THRESHOLD(THR), .CYCLES_PER_SAMPLE(CPS), .DEFAULT_TAU(11'd100)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .sample_valid_in(sample_valid_in),
        .taumin_in(taumin_in), .taumin_valid_in(taumin_valid_in),
        .psola_write_in(psola_write_in), .psola_done_in(psola_done_in),
        .sample_we_out(sample_we_out), .sample_addr_out(sample_addr_out),
        .sample_bank_out(sample_bank_out), .psola_start_out(psola_start_out),
        .psola_bank_out(psola_bank_out), .psola_tau_out(psola_tau_out),
        .read_trigger_out(read_trigger_out), .occupancy_out(occupancy_out),
        .underrun_out(underrun_out), .overrun_out(overrun_out),
        .dropped_window_out(dropped_window_out), .playing_out(playing_out)
    );

    typedef struct packed { logic [AW-1:0] addr; logic bank; } wr_t;
    typedef struct packed { logic bank; logic [10:0] tau; } st_t;
    typedef struct packed {
        logic          write;
        logic [OW-1:0] occ;
        logic          playing;
        logic          read;
        logic          underrun;
        logic          overrun;
    } vec_t;

    wr_t  exp_wr_q[$];
    st_t  exp_st_q[$];
    vec_t vecs[$];
    wr_t  mon_wr;
    st_t  mon_st;
    int   n_vec = 0;
    int   n_err = 0;
    logic [AW-1:0] m_addr;
    logic          m_bank;
    logic [26:0]   all_outs;

    assign all_outs = {sample_we_out, sample_addr_out, sample_bank_out, psola_start_out,
                       psola_bank_out, psola_tau_out, read_trigger_out, occupancy_out,
                       underrun_out, overrun_out, dropped_window_out, playing_out};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drives one full window and queues the write each sample should produce.
    task automatic send_samples(input int n);
        for (int i = 0; i < n; i++) begin
            sample_valid_in = 1'b1;
            exp_wr_q.push_back('{addr: m_addr, bank: m_bank});
            if (m_addr == AW'(WS - 1)) m_bank = ~m_bank;
            m_addr = m_addr + 1'b1;
            tick();
        end
        sample_valid_in = 1'b0;
    endtask

    task automatic run_table(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            psola_write_in = vecs[i].write;
            tick();
            check($sformatf("%s[%0d].occupancy", tag, i), 32'(occupancy_out), 32'(vecs[i].occ));
            check($sformatf("%s[%0d].playing", tag, i), 32'(playing_out), 32'(vecs[i].playing));
            check($sformatf("%s[%0d].read", tag, i), 32'(read_trigger_out), 32'(vecs[i].read));
            check($sformatf("%s[%0d].underrun", tag, i), 32'(underrun_out), 32'(vecs[i].underrun));
            check($sformatf("%s[%0d].overrun", tag, i), 32'(overrun_out), 32'(vecs[i].overrun));
        end
        psola_write_in = 1'b0;
    endtask

    function automatic vec_t mk(input logic w, input int occ, input logic pl,
                                input logic rd, input logic un, input logic ov);
        vec_t v;
        v.write = w; v.occ = OW'(occ); v.playing = pl;
        v.read = rd; v.underrun = un; v.overrun = ov;
        return v;
    endfunction

    always @(negedge clk_in) begin
        if (sample_we_out) begin
            if (exp_wr_q.size() == 0) begin
                check("sample_we_unexpected", 32'(sample_we_out), 32'd0);
            end else begin
                mon_wr = exp_wr_q.pop_front();
                check("sample_addr", 32'(sample_addr_out), 32'(mon_wr.addr));
                check("sample_bank", 32'(sample_bank_out), 32'(mon_wr.bank));
            end
        end
        if (psola_start_out) begin
            if (exp_st_q.size() == 0) begin
                check("psola_start_unexpected", 32'(psola_start_out), 32'd0);
            end else begin
                mon_st = exp_st_q.pop_front();
                check("psola_bank", 32'(psola_bank_out), 32'(mon_st.bank));
                check("psola_tau", 32'(psola_tau_out), 32'(mon_st.tau));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Rows 0..29: prime to 4, play out 4 reads, underrun, idle. Rows 30..37: fill to full from 3.
        //                  w  occ pl rd un ov
        vecs.push_back(mk(1, 1, 0, 0, 0, 0)); vecs.push_back(mk(1, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3, 0, 0, 0, 0)); vecs.push_back(mk(1, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4, 1, 0, 0, 0)); vecs.push_back(mk(0, 4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 4, 1, 0, 0, 0)); vecs.push_back(mk(0, 4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 4, 1, 1, 0, 0)); vecs.push_back(mk(0, 3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 1, 0, 0, 0)); vecs.push_back(mk(0, 3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 1, 1, 0, 0)); vecs.push_back(mk(0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 0, 0, 0)); vecs.push_back(mk(0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 1, 0, 0)); vecs.push_back(mk(0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0)); vecs.push_back(mk(0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0)); vecs.push_back(mk(0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0)); vecs.push_back(mk(0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0)); vecs.push_back(mk(0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0)); vecs.push_back(mk(0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0)); vecs.push_back(mk(0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4, 0, 0, 0, 0)); vecs.push_back(mk(1, 5, 1, 0, 0, 0));
        vecs.push_back(mk(1, 6, 1, 0, 0, 0)); vecs.push_back(mk(1, 7, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8, 1, 0, 0, 0)); vecs.push_back(mk(1, 8, 1, 1, 0, 1));
        vecs.push_back(mk(1, 8, 1, 0, 0, 0)); vecs.push_back(mk(0, 8, 1, 0, 0, 0));

        rst_n_in = 1'b0; sample_valid_in = 1'b0; taumin_in = '0; taumin_valid_in = 1'b0;
        psola_write_in = 1'b0; psola_done_in = 1'b0;
        m_addr = '0; m_bank = 1'b0;
        tick(); tick();
        check("reset_outputs", 32'(all_outs), 32'd0);
        rst_n_in = 1'b1;

        // Window A: default tau, bank 0.
        send_samples(WS);
        check("winA_no_early_start", 32'(psola_start_out), 32'd0);
        exp_st_q.push_back('{bank: 1'b0, tau: 11'd100});
        tick();
        check("winA_start", 32'(psola_start_out), 32'd1);
        tick();
        check("winA_start_pulse_width", 32'(psola_start_out), 32'd0);

        // New tau is latched but the engine output holds until the next start.
        taumin_valid_in = 1'b1; taumin_in = 11'd300;
        tick();
        taumin_valid_in = 1'b0;
        check("tau_held_between_starts", 32'(psola_tau_out), 32'd100);
        psola_done_in = 1'b1;
        tick();
        psola_done_in = 1'b0;

        // Window B: bank 1 with tau 300.
        send_samples(WS);
        exp_st_q.push_back('{bank: 1'b1, tau: 11'd300});
        tick();
        check("winB_start", 32'(psola_start_out), 32'd1);
        tick();

        // Window C while engine still running: dropped, no start.
        send_samples(WS);
        tick();
        check("winC_dropped", 32'(dropped_window_out), 32'd1);
        check("winC_no_start", 32'(psola_start_out), 32'd0);
        tick();
        check("winC_dropped_pulse_width", 32'(dropped_window_out), 32'd0);

        // Window D: done and a new tau coincide with window_ready.
        send_samples(WS);
        psola_done_in = 1'b1; taumin_valid_in = 1'b1; taumin_in = 11'd555;
        exp_st_q.push_back('{bank: 1'b1, tau: 11'd555});
        tick();
        psola_done_in = 1'b0; taumin_valid_in = 1'b0;
        check("winD_start", 32'(psola_start_out), 32'd1);
        check("winD_no_drop", 32'(dropped_window_out), 32'd0);
        psola_done_in = 1'b1;
        tick();
        psola_done_in = 1'b0;

        run_table(0, 29, "play");

        // Occupancy 3 leaves only 5 free: window E must overrun instead of starting.
        psola_write_in = 1'b1;
        tick(); tick(); tick();
        psola_write_in = 1'b0;
        check("pre_winE_occupancy", 32'(occupancy_out), 32'd3);
        send_samples(WS);
        tick();
        check("winE_overrun", 32'(overrun_out), 32'd1);
        check("winE_no_start", 32'(psola_start_out), 32'd0);

        run_table(30, 37, "full");

        // Reset mid-window and mid-play.
        check("playing_before_reset", 32'(playing_out), 32'd1);
        send_samples(3);
        tick();
        rst_n_in = 1'b0;
        tick();
        check("midrun_reset_outputs", 32'(all_outs), 32'd0);
        rst_n_in = 1'b1;
        m_addr = '0; m_bank = 1'b0;

        send_samples(WS);
        exp_st_q.push_back('{bank: 1'b0, tau: 11'd100});
        tick();
        check("post_reset_start", 32'(psola_start_out), 32'd1);
        check("post_reset_tau", 32'(psola_tau_out), 32'd100);
        tick(); tick(); tick();

        check("pending_sample_writes", 32'(exp_wr_q.size()), 32'd0);
        check("pending_engine_starts", 32'(exp_st_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
